// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 scan code decoder with event FIFO and game-key bitmap
//
// Purpose:
//   Pulls raw bytes from a PS/2 keyboard receiver over a level handshake,
//   strips E0 (extended) and F0 (break) prefixes, discards protocol response
//   bytes, queues tagged make/break events and tracks eight game keys.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high
//   scan_ready  receiver has a byte (asynchronous level)
//   scan_code   received byte, stable while scan_ready=1
//   read        acknowledge to receiver; rising edge clears scan_ready
//   ev_valid    event FIFO not empty
//   ev_data     {ext, brk, code[7:0]} of FIFO head (show-ahead)
//   ev_ready    pop FIFO head when ev_valid=1
//   ev_count    FIFO occupancy, 0..2^FIFO_AW
//   overflow    sticky, an event was dropped on a full FIFO
//   key_state   pressed bits: up, down, left, right, W, A, S, D

module ps2_scancode_decoder #(
  parameter int FIFO_AW  = 3,
  parameter int MIN_READ = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               scan_ready,
  input  logic [7:0]         scan_code,
  output logic               read,
  output logic               ev_valid,
  output logic [9:0]         ev_data,
  input  logic               ev_ready,
  output logic [FIFO_AW:0]   ev_count,
  output logic               overflow,
  output logic [7:0]         key_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = (MIN_READ < 2) ? 1 : $clog2(MIN_READ + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // ------------------------------------------------------------------
  // scan_ready synchronizer
  // ------------------------------------------------------------------
  logic rdy_m;
  logic rdy_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      rdy_m <= scan_ready;
      rdy_s <= rdy_m;
    end
  end

  // ------------------------------------------------------------------
  // Handshake FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]  hold_cnt_nxt;
  logic              capture;
  logic [7:0]        byte_r;
  logic              dec_go;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      byte_r   <= 8'h00;
      dec_go   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      dec_go   <= capture;
      if (capture) begin
        byte_r <= scan_code;
      end
    end
  end

  // Leaving ACK waits for both the minimum hold time and the receiver
  // dropping scan_ready, so a stale level can never be captured twice.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    capture      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rdy_s) begin
          capture      = 1'b1;
          hold_cnt_nxt = CNT_W'(MIN_READ);
          state_nxt    = S_ACK;
        end
      end
      S_ACK: begin
        hold_cnt_nxt = (hold_cnt == '0) ? '0 : hold_cnt - 1'b1;
        if ((hold_cnt_nxt == '0) && !rdy_s) begin
          state_nxt = S_WAIT_CLR;
        end
      end
      S_WAIT_CLR: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign read = (state == S_ACK);

  // ------------------------------------------------------------------
  // Byte decode
  // ------------------------------------------------------------------
  logic       ext_r;
  logic       brk_r;
  logic       is_ext;
  logic       is_brk;
  logic       is_filler;
  logic       emit;
  logic       key_hit;
  logic [2:0] key_idx;

  always_comb begin
    is_ext    = (byte_r == CODE_EXT);
    is_brk    = (byte_r == CODE_BRK);
    is_filler = (byte_r == 8'h00) || (byte_r == 8'hAA) || (byte_r == 8'hEE) ||
                (byte_r == 8'hFA) || (byte_r == 8'hFE) || (byte_r == 8'hFF);
    emit      = dec_go && !is_ext && !is_brk && !is_filler;
  end

  // Game-key lookup on the {ext, code} pair.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 3'd0;
    case ({ext_r, byte_r})
      9'h175:  key_idx = 3'd0;
      9'h172:  key_idx = 3'd1;
      9'h16B:  key_idx = 3'd2;
      9'h174:  key_idx = 3'd3;
      9'h01D:  key_idx = 3'd4;
      9'h01C:  key_idx = 3'd5;
      9'h01B:  key_idx = 3'd6;
      9'h023:  key_idx = 3'd7;
      default: key_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_r     <= 1'b0;
      brk_r     <= 1'b0;
      key_state <= 8'h00;
    end else if (dec_go) begin
      if (is_ext) begin
        ext_r <= 1'b1;
      end else if (is_brk) begin
        brk_r <= 1'b1;
      end else if (emit) begin
        if (key_hit) begin
          key_state[key_idx] <= !brk_r;
        end
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Event FIFO (show-ahead, extra pointer bit distinguishes full/empty)
  // ------------------------------------------------------------------
  logic [9:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    ev_count   = wr_ptr - rd_ptr;
    fifo_empty = (ev_count == '0);
    fifo_full  = (ev_count == (FIFO_AW + 1)'(DEPTH));
    do_pop     = ev_ready && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push    = emit && (!fifo_full || do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (emit && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= {ext_r, brk_r, byte_r};
    end
  end

  assign ev_valid = !fifo_empty;
  assign ev_data  = mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - self-checking bench for ps2_scancode_decoder

module tb_ps2_scancode_decoder;

  localparam int FIFO_AW  = 3;
  localparam int MIN_READ = 2;
  localparam int DEPTH    = 1 << FIFO_AW;

  logic             clock = 1'b0;
  logic             reset;
  logic             scan_ready;
  logic [7:0]       scan_code;
  logic             read;
  logic             ev_valid;
  logic [9:0]       ev_data;
  logic             ev_ready;
  logic [FIFO_AW:0] ev_count;
  logic             overflow;
  logic [7:0]       key_state;

  ps2_scancode_decoder #(.FIFO_AW(FIFO_AW), .MIN_READ(MIN_READ)) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_ready (scan_ready),
    .scan_code  (scan_code),
    .read       (read),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .ev_ready   (ev_ready),
    .ev_count   (ev_count),
    .overflow   (overflow),
    .key_state  (key_state)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: plain queue of expected events plus prefix flags.
  logic [9:0] mq[$];
  logic       m_ext;
  logic       m_brk;
  logic       m_ovf;
  logic [7:0] m_key;
  logic [8:0] keymap [8] = '{9'h175, 9'h172, 9'h16B, 9'h174,
                             9'h01D, 9'h01C, 9'h01B, 9'h023};
  logic [7:0] game_codes [8] = '{8'h75, 8'h72, 8'h6B, 8'h74,
                                 8'h1D, 8'h1C, 8'h1B, 8'h23};
  logic [7:0] filler_codes [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  logic [7:0] plain_codes [8] = '{8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    m_key = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (keymap[i] == {m_ext, b}) m_key[i] = !m_brk;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Acts as the receiver: present a byte, drop scan_ready once read rises.
  // Optionally pops the FIFO head in the very cycle the new event is pushed.
  task automatic send(input logic [7:0] b, input bit pop_at_push);
    int n;
    int hi;
    @(negedge clock);
    scan_code  = b;
    scan_ready = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("read_latency", n, 3);
    if (pop_at_push && mq.size() > 0) begin
      check("head_at_push", ev_data, mq.pop_front());
      ev_ready = 1'b1;
    end
    model_byte(b);
    scan_ready = 1'b0;
    hi = 0;
    while (read === 1'b1 && hi < 20) begin
      @(negedge clock);
      ev_ready = 1'b0;
      hi++;
    end
    ev_ready = 1'b0;
    check("read_hold_min", (hi >= MIN_READ && hi < 20), 1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_key_state"}, key_state, m_key);
    check({tag, "_ev_count"}, ev_count, mq.size());
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_ev_valid"}, ev_valid, (mq.size() != 0));
    if (mq.size() > 0) check({tag, "_ev_head"}, ev_data, mq[0]);
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) begin
      check({tag, "_drain_data"}, ev_data, mq.pop_front());
      ev_ready = 1'b1;
      @(negedge clock);
    end
    ev_ready = 1'b0;
    @(negedge clock);
    check({tag, "_drain_empty"}, ev_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] rb;
    int n;
    int r;

    reset      = 1'b1;
    scan_ready = 1'b0;
    scan_code  = 8'h00;
    ev_ready   = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_read", read, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_count", ev_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_key_state", key_state, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single make code.
    send(8'h1C, 1'b0);
    check_state("make_1c");
    check("make_1c_data", ev_data, 10'h01C);
    check("make_1c_key", key_state, 8'h20);
    drain("make_1c");

    // Extended make then extended break of up-arrow.
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    check_state("up_make");
    check("up_make_key0", key_state[0], 1);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    check_state("up_break");
    check("up_break_count", ev_count, 2);
    check("up_break_key0", key_state[0], 0);
    drain("up");

    // Filler bytes between a break prefix and its code.
    send(8'h23, 1'b0);
    drain("d_make");
    send(8'hF0, 1'b0);
    send(8'hFA, 1'b0);
    send(8'hAA, 1'b0);
    send(8'h00, 1'b0);
    send(8'h23, 1'b0);
    check_state("filler");
    check("filler_count", ev_count, 1);
    check("filler_data", ev_data, 10'h123);
    check("filler_key7", key_state[7], 0);
    drain("filler");

    // Overflow: nine makes with nobody popping.
    for (int i = 0; i < 8; i++) send(plain_codes[i], 1'b0);
    send(8'h1B, 1'b0);
    check_state("ovf");
    check("ovf_count", ev_count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_key6", key_state[6], 1);
    drain("ovf");

    // Full FIFO with a pop coinciding with the ninth push.
    do_reset();
    check("rst2_overflow", overflow, 0);
    for (int i = 0; i < 8; i++) send(plain_codes[i], 1'b0);
    send(8'h1C, 1'b1);
    check_state("fullpop");
    check("fullpop_count", ev_count, 8);
    check("fullpop_ovf", overflow, 0);
    drain("fullpop");

    // Reset while read is high after capturing E0.
    @(negedge clock);
    scan_code  = 8'hE0;
    scan_ready = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("midrst_read_high", read, 1);
    reset      = 1'b1;
    scan_ready = 1'b0;
    @(negedge clock);
    check("midrst_read_low", read, 0);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    send(8'h1D, 1'b0);
    check_state("midrst");
    check("midrst_data", ev_data, 10'h01D);
    drain("midrst");

    // Randomized byte stream against the reference model.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      rb = 8'hE0;
      else if (r < 35) rb = 8'hF0;
      else if (r < 45) rb = filler_codes[$urandom_range(0, 5)];
      else if (r < 70) rb = game_codes[$urandom_range(0, 7)];
      else             rb = 8'($urandom_range(0, 255));
      send(rb, 1'b0);
      check_state("rand");
      if ($urandom_range(0, 5) == 0) drain("rand");
    end
    drain("rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
